potential_adder_array: RTL

- Time-multiplexed membrane-potential update engine for NEURONS neurons; the parametrised successor to the single-neuron potential adders.
- Per-neuron config (threshold, model, a/b/c/d) and recovery state u are held in internal register files, loaded over a config port.
- Accepts one (neuron index, weight, decayed potential) update per cycle through a 2-stage pipeline. Emits the new potential and a spike flag.
- Collects spikes into a per-timestep spike vector, released by a timestep-end flush handshake.
- Arithmetic is signed fixed-point Q(DW-FRAC).FRAC, not float.

---
 rtl/potential_adder_array.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/potential_adder_array.sv
// Time-multiplexed potential update engine: 2-stage pipeline, per-neuron cfg/u, timestep spike vector.
// Optional saturating arithmetic: define POTENTIAL_SAT_EN (default wraps modulo 2^DW).
module potential_adder_array #(
  parameter int NEURONS = 10,
  parameter int DW      = 32,
  parameter int FRAC    = 16,
  parameter int IDX_W   = $clog2(NEURONS)
) (
  input  logic               CLK,
  input  logic               clear,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [2:0]         cfg_sel,
  input  logic [DW-1:0]      cfg_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [DW-1:0]      in_weight,
  input  logic [DW-1:0]      in_decayed,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [DW-1:0]      out_potential,
  output logic               out_spike,
  input  logic               ts_end,
  output logic               ts_done,
  output logic [NEURONS-1:0] spike_vector
);

  localparam logic [IDX_W:0] NLIM = NEURONS[IDX_W:0];
  localparam logic [DW-1:0] THR_RST = DW'(200 << FRAC);
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW:0] EMAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] EMIN = {2'b11, {(DW-1){1'b0}}};
  localparam logic signed [2*DW-1:0] PMAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] PMIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic signed [DW-1:0] f_sat(input logic signed [DW:0] s);
`ifdef POTENTIAL_SAT_EN
    if (s > EMAX) return SMAX;
    if (s < EMIN) return SMIN;
`endif
    return DW'(s);
  endfunction

  function automatic logic signed [DW-1:0] f_add(input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
    return f_sat({x[DW-1], x} + {y[DW-1], y});
  endfunction

  function automatic logic signed [DW-1:0] f_sub(input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
    return f_sat({x[DW-1], x} - {y[DW-1], y});
  endfunction

  function automatic logic signed [DW-1:0] f_mul(input logic signed [DW-1:0] x,
                                                 input logic signed [DW-1:0] y);
    logic signed [2*DW-1:0] xe, ye, p;
    xe = {{DW{x[DW-1]}}, x};
    ye = {{DW{y[DW-1]}}, y};
    p  = xe * ye;
    p  = p >>> FRAC;
`ifdef POTENTIAL_SAT_EN
    if (p > PMAX) return SMAX;
    if (p < PMIN) return SMIN;
`endif
    return DW'(p);
  endfunction

  typedef enum logic [1:0] {ST_ACCUM, ST_FLUSH, ST_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic signed [DW-1:0] r_thresh [NEURONS];
  logic signed [DW-1:0] r_a [NEURONS];
  logic signed [DW-1:0] r_b [NEURONS];
  logic signed [DW-1:0] r_c [NEURONS];
  logic signed [DW-1:0] r_d [NEURONS];
  logic signed [DW-1:0] r_u [NEURONS];
  logic [1:0]           r_model [NEURONS];

  logic                 r_s1_v, r_s1_ok;
  logic [IDX_W-1:0]     r_s1_idx;
  logic [1:0]           r_s1_model;
  logic signed [DW-1:0] r_s1_sum, r_s1_dec, r_s1_th, r_s1_u;
  logic signed [DW-1:0] r_s1_a, r_s1_b, r_s1_c, r_s1_d;

  logic                 r_out_valid, r_out_spike;
  logic [IDX_W-1:0]     r_out_idx;
  logic [DW-1:0]        r_out_pot;
  logic [NEURONS-1:0]   r_acc;

  logic                 w_acc, w_in_ok, w_cfg_ok, w_fire, w_u_wb;
  logic [IDX_W-1:0]     w_rd_idx;
  logic signed [DW-1:0] w_u_rd, w_v, w_pot, w_u_new;

  assign w_in_ok  = {1'b0, in_idx} < NLIM;
  assign w_cfg_ok = {1'b0, cfg_idx} < NLIM;
  assign w_rd_idx = w_in_ok ? in_idx : '0;
  assign w_acc    = in_valid && in_ready;
  assign w_u_wb   = r_s1_v && r_s1_ok && (r_s1_model == 2'b01);

  // The entry in S2 writes u at the same edge this read is latched
  assign w_u_rd = (w_u_wb && (r_s1_idx == in_idx)) ? w_u_new : r_u[w_rd_idx];

  always_comb begin
    w_fire  = 1'b0;
    w_v     = r_s1_sum;
    w_pot   = r_s1_sum;
    w_u_new = r_s1_u;
    case (r_s1_model)
      2'b00: begin
        w_fire = w_v >= r_s1_th;
        w_pot  = w_fire ? f_sub(w_v, r_s1_th) : w_v;
      end
      2'b01: begin
        w_v     = f_sub(r_s1_sum, r_s1_u);
        w_fire  = w_v >= r_s1_th;
        w_pot   = w_fire ? r_s1_c : w_v;
        w_u_new = w_fire ? f_add(r_s1_u, r_s1_d)
                : f_add(r_s1_u, f_mul(r_s1_a,
                    f_sub(f_mul(r_s1_b, r_s1_dec), r_s1_u)));
      end
      2'b10: begin
        w_v    = f_add(r_s1_sum, f_mul(r_s1_dec, r_s1_dec));
        w_fire = w_v >= r_s1_th;
        w_pot  = w_fire ? f_sub(w_v, r_s1_th) : w_v;
      end
      default: begin
        w_fire = 1'b0;
        w_pot  = r_s1_sum;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      for (int i = 0; i < NEURONS; i++) begin
        r_thresh[i] <= THR_RST;
        r_a[i]      <= '0;
        r_b[i]      <= '0;
        r_c[i]      <= '0;
        r_d[i]      <= '0;
        r_u[i]      <= '0;
        r_model[i]  <= 2'b00;
      end
    end else begin
      if (cfg_we && w_cfg_ok) begin
        case (cfg_sel)
          3'd0:    r_thresh[cfg_idx] <= cfg_data;
          3'd1:    r_a[cfg_idx]      <= cfg_data;
          3'd2:    r_b[cfg_idx]      <= cfg_data;
          3'd3:    r_c[cfg_idx]      <= cfg_data;
          3'd4:    r_d[cfg_idx]      <= cfg_data;
          3'd5:    r_model[cfg_idx]  <= cfg_data[1:0];
          3'd6:    r_u[cfg_idx]      <= cfg_data;
          default: ;
        endcase
      end
      // Later assignment gives the pipeline priority over a cfg u write
      if (w_u_wb) r_u[r_s1_idx] <= w_u_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_s1_v      <= 1'b0;
      r_s1_ok     <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_model  <= 2'b00;
      r_s1_sum    <= '0;
      r_s1_dec    <= '0;
      r_s1_th     <= '0;
      r_s1_u      <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_c      <= '0;
      r_s1_d      <= '0;
      r_out_valid <= 1'b0;
      r_out_spike <= 1'b0;
      r_out_idx   <= '0;
      r_out_pot   <= '0;
    end else begin
      r_s1_v <= w_acc;
      if (w_acc) begin
        r_s1_ok    <= w_in_ok;
        r_s1_idx   <= in_idx;
        r_s1_model <= r_model[w_rd_idx];
        r_s1_sum   <= f_add(in_weight, in_decayed);
        r_s1_dec   <= in_decayed;
        r_s1_th    <= r_thresh[w_rd_idx];
        r_s1_u     <= w_u_rd;
        r_s1_a     <= r_a[w_rd_idx];
        r_s1_b     <= r_b[w_rd_idx];
        r_s1_c     <= r_c[w_rd_idx];
        r_s1_d     <= r_d[w_rd_idx];
      end
      r_out_valid <= r_s1_v;
      r_out_idx   <= r_s1_v ? r_s1_idx : '0;
      r_out_pot   <= (r_s1_v && r_s1_ok) ? w_pot : '0;
      r_out_spike <= r_s1_v && r_s1_ok && w_fire;
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_acc <= '0;
    end else if (r_state == ST_DONE) begin
      r_acc <= '0;
    end else if (r_out_valid && r_out_spike) begin
      r_acc[r_out_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (clear) r_state <= ST_ACCUM;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    in_ready     = 1'b0;
    ts_done      = 1'b0;
    spike_vector = '0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (ts_end) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!r_s1_v && !r_out_valid) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        ts_done      = 1'b1;
        spike_vector = r_acc;
        w_state_nxt  = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  assign out_valid     = r_out_valid;
  assign out_idx       = r_out_idx;
  assign out_potential = r_out_pot;
  assign out_spike     = r_out_spike;

endmodule
